// File: rtl/fibo_fsm_if.sv
// Control bundle between the Fibonacci sequencer and its register-file/ALU datapath.
// The master side drives the register-file/ALU controls and Done.
// The slave side drives Start and the combinational zero_flag.
interface fibo_fsm_if #(
  parameter int size = 3
);
  // Start/Done is a level handshake. Start is sampled in IDLE and DONE only.
  // Done stays high in DONE until Start is seen low, so a held Start never retriggers.
  logic            Start;
  logic            zero_flag;
  logic [size-2:0] wrt_addr;
  logic            wrt_en;
  logic            load_data;
  logic [size-2:0] rd_addr1;
  logic [size-2:0] rd_addr2;
  logic [size-1:0] alu_opcode;
  logic            Done;
  logic [3:0]      state_dbg;

  modport master (
    input  Start, zero_flag,
    output wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode, Done, state_dbg
  );

  modport slave (
    output Start, zero_flag,
    input  wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode, Done, state_dbg
  );
endinterface

// File: rtl/fibo_fsm.sv
// Moore controller that sequences an external register file and ALU to compute F(N).
// R0 holds the countdown, R1/R2 hold the running pair, and R3 is scratch for the sum.
module fibo_fsm #(
  parameter int size = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  fibo_fsm_if.master  bus
);

  typedef logic [size-2:0] addr_t;
  typedef logic [size-1:0] op_t;

  localparam op_t OP_PASS = op_t'(0);
  localparam op_t OP_ADD  = op_t'(1);
  localparam op_t OP_DEC  = op_t'(3);
  localparam op_t OP_INC  = op_t'(4);
  localparam op_t OP_CLR  = op_t'(5);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_N = 4'd1,
    INIT_A = 4'd2,
    INIT_B = 4'd3,
    CHECK  = 4'd4,
    ADD    = 4'd5,
    MOV1   = 4'd6,
    MOV2   = 4'd7,
    DEC    = 4'd8,
    DONE   = 4'd9
  } state_t;

  typedef struct packed {
    addr_t wa;
    logic  we;
    logic  ld;
    addr_t r1;
    addr_t r2;
    op_t   op;
    logic  done;
  } ctl_t;

  state_t state;
  ctl_t   ctl;

  function automatic state_t next_of(state_t s, logic start, logic zf);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:    n = start ? LOAD_N : IDLE;
      LOAD_N:  n = INIT_A;
      INIT_A:  n = INIT_B;
      INIT_B:  n = CHECK;
      CHECK:   n = zf ? DONE : ADD;
      ADD:     n = MOV1;
      MOV1:    n = MOV2;
      MOV2:    n = DEC;
      DEC:     n = CHECK;
      DONE:    n = start ? DONE : IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Output word for a given state; anything not listed stays zero.
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      LOAD_N: begin c.ld = 1'b1; c.we = 1'b1; c.wa = addr_t'(0); end
      INIT_A: begin c.op = OP_CLR; c.we = 1'b1; c.wa = addr_t'(1); end
      INIT_B: begin c.op = OP_INC; c.r1 = addr_t'(1); c.we = 1'b1; c.wa = addr_t'(2); end
      CHECK:  begin c.op = OP_PASS; c.r1 = addr_t'(0); end
      ADD:    begin
        c.op = OP_ADD; c.r1 = addr_t'(1); c.r2 = addr_t'(2);
        c.we = 1'b1;   c.wa = addr_t'(3);
      end
      MOV1:   begin c.op = OP_PASS; c.r1 = addr_t'(2); c.we = 1'b1; c.wa = addr_t'(1); end
      MOV2:   begin c.op = OP_PASS; c.r1 = addr_t'(3); c.we = 1'b1; c.wa = addr_t'(2); end
      DEC:    begin c.op = OP_DEC; c.r1 = addr_t'(0); c.we = 1'b1; c.wa = addr_t'(0); end
      DONE:   c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered from the next state, so they always equal decode(state).
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= next_of(state, bus.Start, bus.zero_flag);
      ctl   <= decode(next_of(state, bus.Start, bus.zero_flag));
    end
  end

  assign bus.wrt_addr   = ctl.wa;
  assign bus.wrt_en     = ctl.we;
  assign bus.load_data  = ctl.ld;
  assign bus.rd_addr1   = ctl.r1;
  assign bus.rd_addr2   = ctl.r2;
  assign bus.alu_opcode = ctl.op;
  assign bus.Done       = ctl.done;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_fibo_fsm.sv
// Bench for fibo_fsm: a behavioural register file/ALU closes the loop, and a
// state-sequence scoreboard checks every cycle's outputs against the state table.
module tb_fibo_fsm;
  localparam int size = 3;

  localparam logic [3:0] S_IDLE = 4'd0, S_LOAD = 4'd1, S_INIT_A = 4'd2, S_INIT_B = 4'd3;
  localparam logic [3:0] S_CHECK = 4'd4, S_ADD = 4'd5, S_MOV1 = 4'd6, S_MOV2 = 4'd7;
  localparam logic [3:0] S_DEC = 4'd8, S_DONE = 4'd9;

  typedef struct packed {
    logic [1:0] wa;
    logic       we;
    logic       ld;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [2:0] op;
    logic       done;
  } ctl_exp_t;

  typedef struct {
    int          n;
    logic [15:0] fib;
  } run_vec_t;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  fibo_fsm_if #(.size(size)) bus ();
  fibo_fsm #(.size(size)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  // Behavioural datapath
  logic [15:0] rf [4];
  logic [15:0] n_in;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        zf_force_zero;

  always_comb begin
    alu_a = rf[bus.rd_addr1];
    alu_b = rf[bus.rd_addr2];
    case (bus.alu_opcode)
      3'd0:    alu_res = alu_a;
      3'd1:    alu_res = alu_a + alu_b;
      3'd2:    alu_res = alu_a - alu_b;
      3'd3:    alu_res = alu_a - 16'd1;
      3'd4:    alu_res = alu_a + 16'd1;
      default: alu_res = 16'd0;
    endcase
  end

  assign bus.zero_flag = zf_force_zero ? 1'b0 : (alu_res == 16'd0);

  always @(posedge Clk) begin
    if (bus.wrt_en) rf[bus.wrt_addr] <= bus.load_data ? n_in : alu_res;
  end

  // Scoreboard
  logic [3:0] exp_q[$];
  ctl_exp_t   tbl [16];
  run_vec_t   runs [7];
  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] fib_ref(int n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    for (int k = 0; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_state(input logic [3:0] s, input string tag);
    ctl_exp_t act;
    act = {bus.wrt_addr, bus.wrt_en, bus.load_data, bus.rd_addr1, bus.rd_addr2,
           bus.alu_opcode, bus.Done};
    checks++;
    if (bus.state_dbg !== s || act !== tbl[s]) begin
      failures++;
      $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
               tag, bus.state_dbg, act, s, tbl[s]);
    end
  endtask

  task automatic check_fib(input logic [15:0] exp_f, input string tag);
    checks++;
    if (rf[1] !== exp_f) begin
      failures++;
      $display("FAIL %s: R1=%0d, required %0d", tag, rf[1], exp_f);
    end
  endtask

  task automatic push_loops(input int loops);
    for (int k = 0; k < loops; k++) begin
      exp_q.push_back(S_CHECK);
      exp_q.push_back(S_ADD);
      exp_q.push_back(S_MOV1);
      exp_q.push_back(S_MOV2);
      exp_q.push_back(S_DEC);
    end
  endtask

  task automatic push_run(input int n);
    exp_q.push_back(S_LOAD);
    exp_q.push_back(S_INIT_A);
    exp_q.push_back(S_INIT_B);
    push_loops(n);
    exp_q.push_back(S_CHECK);
    exp_q.push_back(S_DONE);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      step();
      check_state(exp_q.pop_front(), tag);
    end
  endtask

  task automatic do_run(input int n, input logic [15:0] exp_f, input string tag);
    n_in = 16'(n);
    bus.Start = 1'b1;
    push_run(n);
    drain(tag);
    check_fib(exp_f, tag);
    bus.Start = 1'b0;
    step();
    check_state(S_IDLE, tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tbl[S_LOAD]   = '{wa: 2'd0, we: 1'b1, ld: 1'b1, r1: 2'd0, r2: 2'd0, op: 3'd0, done: 1'b0};
    tbl[S_INIT_A] = '{wa: 2'd1, we: 1'b1, ld: 1'b0, r1: 2'd0, r2: 2'd0, op: 3'd5, done: 1'b0};
    tbl[S_INIT_B] = '{wa: 2'd2, we: 1'b1, ld: 1'b0, r1: 2'd1, r2: 2'd0, op: 3'd4, done: 1'b0};
    tbl[S_CHECK]  = '{wa: 2'd0, we: 1'b0, ld: 1'b0, r1: 2'd0, r2: 2'd0, op: 3'd0, done: 1'b0};
    tbl[S_ADD]    = '{wa: 2'd3, we: 1'b1, ld: 1'b0, r1: 2'd1, r2: 2'd2, op: 3'd1, done: 1'b0};
    tbl[S_MOV1]   = '{wa: 2'd1, we: 1'b1, ld: 1'b0, r1: 2'd2, r2: 2'd0, op: 3'd0, done: 1'b0};
    tbl[S_MOV2]   = '{wa: 2'd2, we: 1'b1, ld: 1'b0, r1: 2'd3, r2: 2'd0, op: 3'd0, done: 1'b0};
    tbl[S_DEC]    = '{wa: 2'd0, we: 1'b1, ld: 1'b0, r1: 2'd0, r2: 2'd0, op: 3'd3, done: 1'b0};
    tbl[S_DONE]   = '{wa: 2'd0, we: 1'b0, ld: 1'b0, r1: 2'd0, r2: 2'd0, op: 3'd0, done: 1'b1};

    runs[0] = '{n: 0,  fib: 16'd0};
    runs[1] = '{n: 1,  fib: 16'd1};
    runs[2] = '{n: 2,  fib: 16'd1};
    runs[3] = '{n: 3,  fib: 16'd2};
    runs[4] = '{n: 5,  fib: 16'd5};
    runs[5] = '{n: 7,  fib: 16'd13};
    runs[6] = '{n: 10, fib: 16'd55};

    for (int i = 0; i < 4; i++) rf[i] = 16'd0;
    zf_force_zero = 1'b0;
    n_in = 16'd1;
    bus.Start = 1'b1;
    Rst = 1'b0;

    // Reset held with Start high: IDLE, all outputs zero
    repeat (2) begin
      step();
      check_state(S_IDLE, "reset_hold");
    end
    Rst = 1'b1;
    push_run(1);
    drain("reset_release_n1");
    check_fib(16'd1, "reset_release_n1");

    // Held Start keeps DONE; dropping it returns to IDLE
    repeat (3) begin
      step();
      check_state(S_DONE, "done_hold");
    end
    bus.Start = 1'b0;
    step();
    check_state(S_IDLE, "done_to_idle");
    step();
    check_state(S_IDLE, "idle_stay");

    for (int i = 0; i < 7; i++) do_run(runs[i].n, runs[i].fib, $sformatf("run_n%0d", runs[i].n));

    for (int i = 0; i < 2; i++) begin
      int n;
      n = int'($urandom_range(0, 12));
      do_run(n, fib_ref(n), $sformatf("rand_n%0d", n));
    end

    // zero_flag never asserted: loops forever, then reset during MOV2
    zf_force_zero = 1'b1;
    n_in = 16'd5;
    bus.Start = 1'b1;
    exp_q.push_back(S_LOAD);
    exp_q.push_back(S_INIT_A);
    exp_q.push_back(S_INIT_B);
    push_loops(8);
    exp_q.push_back(S_CHECK);
    exp_q.push_back(S_ADD);
    exp_q.push_back(S_MOV1);
    exp_q.push_back(S_MOV2);
    drain("no_zero_loop");
    #2;
    Rst = 1'b0;
    #1;
    check_state(S_IDLE, "async_reset");
    step();
    check_state(S_IDLE, "reset_in_loop");
    Rst = 1'b1;
    zf_force_zero = 1'b0;
    do_run(4, 16'd3, "after_abort_n4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
